amigapci_tack_engine: RTL

//  Parametrised 68040 bus-cycle terminator, successor to the fixed ROM/CIA/Agnus/autoconfig ack logic.

---
 rtl/amigapci_tack_if.sv | 35 +++
 rtl/amigapci_tack_engine.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/amigapci_tack_if.sv
// amigapci_tack_if: 68040 cycle-termination bus between CPU/decoder side and the ack engine.
//   master: drives TSn, SIZ, SEL, per-region WS/BURST_EN/CACHE_INH/EXT_MODE and EXT_ACK;
//           observes TACK_OUTn, TEA_OUTn, TBIn, TCIn, ACK_OE, BUSY, ACTIVE_CH.
//   slave : the termination engine, the mirror image of master.
interface amigapci_tack_if #(
  parameter int unsigned N_REG = 4,
  parameter int unsigned WS_W  = 4,
  parameter int unsigned CH_W  = 2
);
  logic                    TSn;
  logic [1:0]              SIZ;
  logic [N_REG-1:0]        SEL;
  logic [N_REG*WS_W-1:0]   WS;
  logic [N_REG-1:0]        BURST_EN;
  logic [N_REG-1:0]        CACHE_INH;
  logic [N_REG-1:0]        EXT_MODE;
  logic [N_REG-1:0]        EXT_ACK;
  logic                    TACK_OUTn;
  logic                    TEA_OUTn;
  logic                    TBIn;
  logic                    TCIn;
  logic                    ACK_OE;
  logic                    BUSY;
  logic [CH_W-1:0]         ACTIVE_CH;

  modport master (
    output TSn, SIZ, SEL, WS, BURST_EN, CACHE_INH, EXT_MODE, EXT_ACK,
    input  TACK_OUTn, TEA_OUTn, TBIn, TCIn, ACK_OE, BUSY, ACTIVE_CH
  );

  modport slave (
    input  TSn, SIZ, SEL, WS, BURST_EN, CACHE_INH, EXT_MODE, EXT_ACK,
    output TACK_OUTn, TEA_OUTn, TBIn, TCIn, ACK_OE, BUSY, ACTIVE_CH
  );
endinterface

// File: rtl/amigapci_tack_engine.sv
// amigapci_tack_engine: parametrised 68040 bus-cycle terminator for N decoded regions.
//   CLK40  : bus clock, rising edge
//   RESET  : asynchronous active-high reset
//   bus    : amigapci_tack_if.slave -- TSn/SIZ/SEL and per-region config in,
//            TACK_OUTn/TEA_OUTn/TBIn/TCIn/ACK_OE/BUSY/ACTIVE_CH out (all registered).
// A cycle is claimed when TSn is low with any SEL bit set while idle. Internal regions
// ack after their wait-state count; external regions wait for EXT_ACK or raise TEA on
// timeout. Line transfers to burst-capable regions get four beats.
module amigapci_tack_engine #(
  parameter int unsigned N_REG   = 4,
  parameter int unsigned WS_W    = 4,
  parameter int unsigned BEAT_WS = 1,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CH_W    = 2
) (
  input logic              CLK40,
  input logic              RESET,
  amigapci_tack_if.slave   bus
);

  localparam int unsigned CNT_W = (WS_W > 2) ? WS_W : 2;
  localparam int unsigned TMR_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACK    = 3'd2,
    S_NEGATE = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [1:0]        beat_q, beat_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              line_q, line_d;
  logic              burst_q, burst_d;
  logic              inh_q, inh_d;
  logic              ext_q, ext_d;
  logic              tack_q, tack_d;
  logic              tea_q, tea_d;
  logic              tbi_q, tbi_d;
  logic              tci_q, tci_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;

  logic [CH_W-1:0]   sel_ch;
  logic [WS_W-1:0]   sel_ws;
  logic              sel_burst, sel_inh, sel_ext;
  logic              ext_ack_ch;

  // Lowest set SEL bit wins; gather that region's configuration.
  always_comb begin
    sel_ch    = '0;
    sel_ws    = '0;
    sel_burst = 1'b0;
    sel_inh   = 1'b0;
    sel_ext   = 1'b0;
    for (int i = int'(N_REG) - 1; i >= 0; i--) begin
      if (bus.SEL[i]) begin
        sel_ch    = CH_W'(i);
        sel_ws    = bus.WS[i*WS_W +: WS_W];
        sel_burst = bus.BURST_EN[i];
        sel_inh   = bus.CACHE_INH[i];
        sel_ext   = bus.EXT_MODE[i];
      end
    end
  end

  // Only the owning region's EXT_ACK is honoured.
  always_comb begin
    ext_ack_ch = 1'b0;
    for (int i = 0; i < int'(N_REG); i++) begin
      if (ch_q == CH_W'(i)) ext_ack_ch = bus.EXT_ACK[i];
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    beat_d  = beat_q;
    ch_d    = ch_q;
    line_d  = line_q;
    burst_d = burst_q;
    inh_d   = inh_q;
    ext_d   = ext_q;

    case (state_q)
      S_IDLE: begin
        if (!bus.TSn && (|bus.SEL)) begin
          ch_d    = sel_ch;
          line_d  = (bus.SIZ == 2'b11);
          burst_d = sel_burst;
          inh_d   = sel_inh;
          ext_d   = sel_ext;
          beat_d  = '0;
          if (sel_ext) begin
            state_d = S_WAIT;
            tmr_d   = TMR_W'(TIMEOUT);
          end else if (sel_ws == '0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(sel_ws);
          end
        end
      end
      S_WAIT: begin
        if (ext_q) begin
          // A slave ack on the expiry edge still wins over the timeout.
          if (ext_ack_ch) begin
            state_d = S_ACK;
          end else if (tmr_q <= TMR_W'(1)) begin
            state_d = S_ERR;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end else begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = S_ACK;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_ACK: begin
        if (line_q && burst_q && (beat_q != 2'd3)) begin
          beat_d = beat_q + 2'd1;
          if (ext_q) begin
            state_d = S_WAIT;
            tmr_d   = TMR_W'(TIMEOUT);
          end else if (BEAT_WS == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(BEAT_WS);
          end
        end else begin
          beat_d  = '0;
          state_d = S_NEGATE;
        end
      end
      S_ERR: begin
        beat_d  = '0;
        state_d = S_NEGATE;
      end
      S_NEGATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs follow the state being entered so they are valid for that whole cycle.
    tack_d = (state_d != S_ACK);
    tea_d  = (state_d != S_ERR);
    tbi_d  = !((state_d == S_ACK) && line_d && !burst_d);
    tci_d  = !((state_d == S_ACK) && inh_d);
    oe_d   = (state_d != S_IDLE);
    busy_d = (state_d != S_IDLE);
  end

  // State, context and output registers.
  always_ff @(posedge CLK40 or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      beat_q  <= '0;
      ch_q    <= '0;
      line_q  <= 1'b0;
      burst_q <= 1'b0;
      inh_q   <= 1'b0;
      ext_q   <= 1'b0;
      tack_q  <= 1'b1;
      tea_q   <= 1'b1;
      tbi_q   <= 1'b1;
      tci_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      beat_q  <= beat_d;
      ch_q    <= ch_d;
      line_q  <= line_d;
      burst_q <= burst_d;
      inh_q   <= inh_d;
      ext_q   <= ext_d;
      tack_q  <= tack_d;
      tea_q   <= tea_d;
      tbi_q   <= tbi_d;
      tci_q   <= tci_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.TACK_OUTn = tack_q;
  assign bus.TEA_OUTn  = tea_q;
  assign bus.TBIn      = tbi_q;
  assign bus.TCIn      = tci_q;
  assign bus.ACK_OE    = oe_q;
  assign bus.BUSY      = busy_q;
  assign bus.ACTIVE_CH = ch_q;

endmodule
